// File: rtl/word_packer_pkg.sv
// Shared types and defaults for the word packer: word/beat/mask typedefs and index sizing.
package word_packer_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultNumWords  = 2;
  localparam int unsigned IdxWidth         = $clog2(DefaultNumWords);

  typedef logic [DefaultDataWidth-1:0]                      word_t;
  typedef logic [DefaultNumWords-1:0][DefaultDataWidth-1:0] beat_t;
  typedef logic [DefaultNumWords-1:0]                       mask_t;

  // Width of the fill index for an arbitrary word count (never below one bit).
  function automatic int unsigned idx_width(input int unsigned num_words);
    return (num_words < 2) ? 1 : $clog2(num_words);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs NumWords input words into one beat with a word-valid mask; in_last_i closes a partial beat.
// The finished beat sits in a registered valid/ready output stage that may be refilled on the cycle it is taken.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int unsigned DataWidth = DefaultDataWidth,
  parameter int unsigned NumWords  = DefaultNumWords
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [DataWidth-1:0]               in_data_i,
  input  logic                               in_last_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [NumWords-1:0][DataWidth-1:0] out_data_o,
  output logic [NumWords-1:0]                out_mask_o,
  output logic                               out_last_o
);

  localparam int unsigned IdxW = idx_width(NumWords);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

  typedef logic [NumWords-1:0][DataWidth-1:0] lbeat_t;
  typedef logic [NumWords-1:0]                lmask_t;

  if ($bits(lbeat_t) != NumWords * DataWidth) begin : g_beat_size_check
    $error("word_packer: beat type width does not equal NumWords*DataWidth");
  end
  if (NumWords < 2) begin : g_num_words_check
    $error("word_packer: NumWords must be at least 2");
  end

  lbeat_t          acc_q, acc_d, merged;
  lmask_t          acc_mask_q, acc_mask_d, merged_mask;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            out_valid_q, out_valid_d;
  lbeat_t          out_data_q, out_data_d;
  lmask_t          out_mask_q, out_mask_d;
  logic            out_last_q, out_last_d;
  logic            in_ready;
  logic            accept;

  // Fill only stalls while a finished beat is still waiting downstream.
  assign in_ready = ~rst_i & (~out_valid_q | out_ready_i);
  assign accept   = in_valid_i & in_ready;

  always_comb begin
    merged      = acc_q;
    merged_mask = acc_mask_q;
    acc_d       = acc_q;
    acc_mask_d  = acc_mask_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q & ~out_ready_i;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;

    if (accept) begin
      merged[idx_q]      = in_data_i;
      merged_mask[idx_q] = 1'b1;
      if ((idx_q == LastIdx) || in_last_i) begin
        out_valid_d = 1'b1;
        out_data_d  = merged;
        out_mask_d  = merged_mask;
        out_last_d  = in_last_i;
        acc_d       = '0;
        acc_mask_d  = '0;
        idx_d       = '0;
      end else begin
        acc_d      = merged;
        acc_mask_d = merged_mask;
        idx_d      = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      acc_mask_q  <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      acc_mask_q  <= acc_mask_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_mask_o  = out_mask_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_word_packer.sv
// Directed checks of word_packer at 2x32, plus a randomized-handshake scoreboard run at 4x8.
module tb_word_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // default 2x32 instance
  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
  logic [31:0] a_in_data;
  logic [1:0][31:0] a_out_data;
  logic [1:0]  a_out_mask;
  // 4x8 instance
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_in_data;
  logic [3:0][7:0] b_out_data;
  logic [3:0]  b_out_mask;

  word_packer u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data), .in_last_i(a_in_last),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .out_mask_o(a_out_mask), .out_last_o(a_out_last)
  );

  word_packer #(.DataWidth(8), .NumWords(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data), .in_last_i(b_in_last),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_mask_o(b_out_mask), .out_last_o(b_out_last)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] data, input logic [1:0] mask,
                          input logic last);
    chk({tag, "_valid"}, 64'(a_out_valid), 64'd1);
    chk({tag, "_data"},  a_out_data, data);
    chk({tag, "_mask"},  64'(a_out_mask), 64'(mask));
    chk({tag, "_last"},  64'(a_out_last), 64'(last));
  endtask

  // scoreboard state for the 4x8 instance
  logic [3:0][7:0] m_acc;
  logic [3:0]      m_mask;
  int              m_idx;
  logic [31:0]     q_data[$];
  logic [3:0]      q_mask[$];
  logic            q_last[$];
  logic            exp_rdy, do_acc;

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_last = 0; a_in_data = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_last = 0; b_in_data = '0; b_out_ready = 1;

    // reset state
    tick(); tick();
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_data",  a_out_data, 64'd0);
    chk("rst_mask",  64'(a_out_mask), 64'd0);
    chk("rst_last",  64'(a_out_last), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd0);
    rst = 1'b0;
    tick();

    // 1: two words form one beat, visible one cycle after the second
    a_in_valid = 1; a_in_data = 32'hAAAA_0001; tick();
    chk("t1_not_yet", 64'(a_out_valid), 64'd0);
    a_in_data = 32'hBBBB_0002; tick();
    chk_beat("t1", {32'hBBBB_0002, 32'hAAAA_0001}, 2'b11, 1'b0);
    a_in_valid = 0; tick();
    chk("t1_taken", 64'(a_out_valid), 64'd0);

    // 2: continuous stream, full throughput
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1; a_in_data = 32'(100 + i);
      #1;
      chk("t2_in_ready", 64'(a_in_ready), 64'd1);
      tick();
      if (i % 2 == 1) begin
        chk("t2_valid", 64'(a_out_valid), 64'd1);
        chk("t2_data", a_out_data, {32'(100 + i), 32'(99 + i)});
      end else begin
        chk("t2_idle", 64'(a_out_valid), 64'd0);
      end
    end
    a_in_valid = 0; tick();

    // 3: in_last on the first word closes a one-word beat; next beat restarts at slot 0
    a_in_valid = 1; a_in_last = 1; a_in_data = 32'hCCCC_0003; tick();
    chk_beat("t3", {32'h0, 32'hCCCC_0003}, 2'b01, 1'b1);
    a_in_last = 0; a_in_data = 32'hDDDD_0004; tick();
    chk("t3_partial", 64'(a_out_valid), 64'd0);
    a_in_data = 32'hEEEE_0005; tick();
    chk_beat("t3_next", {32'hEEEE_0005, 32'hDDDD_0004}, 2'b11, 1'b0);
    a_in_valid = 0; tick();

    // 4: backpressure holds the beat and stalls input; varying stalled data is ignored
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'hF0F0_0006; tick();
    a_in_data = 32'h1616_0007; tick();
    chk_beat("t4_first", {32'h1616_0007, 32'hF0F0_0006}, 2'b11, 1'b0);
    for (int k = 0; k < 5; k++) begin
      a_in_data = 32'hDEAD_0000 + 32'(k);
      #1;
      chk("t4_stall_ready", 64'(a_in_ready), 64'd0);
      tick();
      chk_beat("t4_hold", {32'h1616_0007, 32'hF0F0_0006}, 2'b11, 1'b0);
    end
    a_in_data = 32'h4848_0008; a_out_ready = 1; tick();
    chk("t4_release", 64'(a_out_valid), 64'd0);
    a_in_data = 32'h4949_0009; tick();
    chk_beat("t4_after", {32'h4949_0009, 32'h4848_0008}, 2'b11, 1'b0);
    a_in_valid = 0; tick();

    // 5: reset mid-beat drops the partial word
    a_in_valid = 1; a_in_data = 32'h0000_00A1; tick();
    a_in_valid = 0; rst = 1;
    #1;
    chk("t5_rst_ready", 64'(a_in_ready), 64'd0);
    tick();
    rst = 0; tick(); tick();
    chk("t5_no_out", 64'(a_out_valid), 64'd0);
    chk("t5_mask", 64'(a_out_mask), 64'd0);
    a_in_valid = 1; a_in_data = 32'h0000_00B2; tick();
    chk("t5_clean_start", 64'(a_out_valid), 64'd0);
    a_in_data = 32'h0000_00C3; tick();
    chk_beat("t5", {32'h0000_00C3, 32'h0000_00B2}, 2'b11, 1'b0);
    a_in_valid = 0; tick();

    // 6: 4x8 with random valid/ready/last against an in-order packing model
    m_acc = '0; m_mask = '0; m_idx = 0;
    for (int c = 0; c < 600; c++) begin
      if (c < 590) begin
        b_in_valid  = 1'($urandom_range(0, 1));
        b_in_last   = ($urandom_range(0, 5) == 0);
        b_in_data   = 8'($urandom);
        b_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        b_in_valid = 0; b_in_last = 0; b_out_ready = 1;
      end
      #1;
      exp_rdy = (q_data.size() == 0) || b_out_ready;
      chk("t6_out_valid", 64'(b_out_valid), 64'(q_data.size() != 0));
      chk("t6_in_ready", 64'(b_in_ready), 64'(exp_rdy));
      if (q_data.size() != 0 && b_out_ready) begin
        chk("t6_data", 64'(b_out_data), 64'(q_data.pop_front()));
        chk("t6_mask", 64'(b_out_mask), 64'(q_mask.pop_front()));
        chk("t6_last", 64'(b_out_last), 64'(q_last.pop_front()));
      end
      do_acc = b_in_valid && exp_rdy;
      if (do_acc) begin
        m_acc[m_idx]  = b_in_data;
        m_mask[m_idx] = 1'b1;
        if (m_idx == 3 || b_in_last) begin
          q_data.push_back(m_acc);
          q_mask.push_back(m_mask);
          q_last.push_back(b_in_last);
          m_acc = '0; m_mask = '0; m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      tick();
    end
    chk("t6_drained", 64'(b_out_valid), 64'(q_data.size() != 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
